counter64_snapshot_reader: RTL and testbench

- Downstream consumer of a bank of 64-bit event counters. Each counter exposes a live MSB, a sampled LSB, a sample strobe input and a synchronous clear input.
- Arbitrates 32-bit API register reads and writes onto NUM_COUNTERS counters.
- Guarantees a coherent 64-bit snapshot: MSB and LSB are captured on the same clock edge.
- Sits between the API bus decoder and the statistics counter instances in the NTS engine.

---
 rtl/counter64_pkg.sv | 21 ++
 rtl/counter64_snapshot_reader_if.sv | 22 ++
 rtl/counter64_index_mux.sv | 19 +
 rtl/counter64_snapshot_reader.sv | 132 +++++++++++++
 tb/tb_counter64_snapshot_reader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter64_pkg.sv
// Shared constants for the counter64 snapshot reader: register offsets,
// FSM encoding and CTRL register bit positions.
package counter64_pkg;

    localparam logic [1:0] OFS_MSB  = 2'd0;
    localparam logic [1:0] OFS_LSB  = 2'd1;
    localparam logic [1:0] OFS_CTRL = 2'd2;

    localparam int CTRL_BIT_RST = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SAMPLE = ST_SAMPLE,
        RESP   = ST_RESP
    } state_e;

endpackage

// File: rtl/counter64_snapshot_reader_if.sv
// API register bus between the bus decoder (master) and the snapshot reader (slave).
interface counter64_snapshot_reader_if #(
    parameter int IDX_W = 4
);
    logic             cs;
    logic             we;
    logic [IDX_W+1:0] address;
    logic [31:0]      write_data;
    logic [31:0]      read_data;
    logic             ready;
    logic             busy;

    modport master (
        output cs, we, address, write_data,
        input  read_data, ready, busy
    );

    modport slave (
        input  cs, we, address, write_data,
        output read_data, ready, busy
    );
endinterface

// File: rtl/counter64_index_mux.sv
// Combinational 32-bit N-to-1 selector over a flattened counter bus.
// Out-of-range selects return zero.
module counter64_index_mux #(
    parameter int NUM_COUNTERS = 8,
    parameter int IDX_W        = 4
) (
    input  logic [32*NUM_COUNTERS-1:0] bus_i,
    input  logic [IDX_W-1:0]           sel_i,
    output logic [31:0]                data_o
);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (sel_i == IDX_W'(k)) data_o = bus_i[32*k +: 32];
        end
    end

endmodule

// File: rtl/counter64_snapshot_reader.sv
// Arbitrates 32-bit API accesses onto a bank of 64-bit counters and returns
// coherent MSB/LSB snapshots (both halves captured on the same edge).
module counter64_snapshot_reader
    import counter64_pkg::*;
#(
    parameter int NUM_COUNTERS = 8,
    parameter int IDX_W        = 4
) (
    input  logic                          i_areset,
    input  logic                          i_clk,
    counter64_snapshot_reader_if.slave    api,
    input  logic [32*NUM_COUNTERS-1:0]    i_msb,
    input  logic [32*NUM_COUNTERS-1:0]    i_lsb,
    output logic [NUM_COUNTERS-1:0]       o_lsb_sample,
    output logic [NUM_COUNTERS-1:0]       o_cnt_rst
);

    localparam logic [NUM_COUNTERS-1:0] ONE = NUM_COUNTERS'(1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              ofs_q, ofs_d;
    logic                    we_q, we_d;
    logic [31:0]             msb_hold_q, msb_hold_d;
    logic [NUM_COUNTERS-1:0] lsb_sample_q, lsb_sample_d;
    logic [NUM_COUNTERS-1:0] cnt_rst_q, cnt_rst_d;
    logic                    ready_q, ready_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    clr_wait_q, clr_wait_d;

    logic [IDX_W-1:0]        req_idx;
    logic [1:0]              req_ofs;
    logic [NUM_COUNTERS-1:0] req_oh;
    logic                    req_rst_bit;
    logic [31:0]             msb_sel, lsb_sel;

    assign req_idx     = api.address[IDX_W+1:2];
    assign req_ofs     = api.address[1:0];
    // Shifting past the top bit leaves zero, so out-of-range indices strobe nothing.
    assign req_oh      = ONE << req_idx;
    assign req_rst_bit = |(api.write_data & (32'd1 << CTRL_BIT_RST));

    counter64_index_mux #(.NUM_COUNTERS(NUM_COUNTERS), .IDX_W(IDX_W)) u_msb_mux (
        .bus_i  (i_msb),
        .sel_i  (idx_q),
        .data_o (msb_sel)
    );

    counter64_index_mux #(.NUM_COUNTERS(NUM_COUNTERS), .IDX_W(IDX_W)) u_lsb_mux (
        .bus_i  (i_lsb),
        .sel_i  (idx_q),
        .data_o (lsb_sel)
    );

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ofs_q        <= '0;
            we_q         <= 1'b0;
            msb_hold_q   <= '0;
            lsb_sample_q <= '0;
            cnt_rst_q    <= '0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            clr_wait_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ofs_q        <= ofs_d;
            we_q         <= we_d;
            msb_hold_q   <= msb_hold_d;
            lsb_sample_q <= lsb_sample_d;
            cnt_rst_q    <= cnt_rst_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            clr_wait_q   <= clr_wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ofs_d        = ofs_q;
        we_d         = we_q;
        msb_hold_d   = msb_hold_q;
        lsb_sample_d = '0;
        cnt_rst_d    = '0;
        ready_d      = 1'b0;
        rdata_d      = '0;
        clr_wait_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (api.cs && !clr_wait_q) begin
                    idx_d = req_idx;
                    ofs_d = req_ofs;
                    we_d  = api.we;
                    if (!api.we && req_ofs == OFS_MSB) begin
                        state_d      = SAMPLE;
                        lsb_sample_d = req_oh;
                    end else begin
                        state_d = RESP;
                        if (api.we && req_ofs == OFS_CTRL && req_rst_bit) cnt_rst_d = req_oh;
                    end
                end
            end
            SAMPLE: begin
                // Same edge that loads the counter's LSB sample register.
                msb_hold_d = msb_sel;
                state_d    = RESP;
            end
            RESP: begin
                ready_d    = 1'b1;
                state_d    = IDLE;
                // Counter clear input is registered: hold off one more cycle.
                clr_wait_d = |cnt_rst_q;
                if (!we_q) begin
                    if (ofs_q == OFS_MSB)      rdata_d = msb_hold_q;
                    else if (ofs_q == OFS_LSB) rdata_d = lsb_sel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign api.ready     = ready_q;
    assign api.read_data = rdata_q;
    assign api.busy      = (state_q != IDLE) || clr_wait_q;
    assign o_lsb_sample  = lsb_sample_q;
    assign o_cnt_rst     = cnt_rst_q;

endmodule

// File: tb/tb_counter64_snapshot_reader.sv
// Scoreboard bench for counter64_snapshot_reader driving a modelled bank of
// eight counter64 instances (sampled LSB register, registered clear).
module tb_counter64_snapshot_reader;

    localparam int N     = 8;
    localparam int IDX_W = 4;

    logic i_clk = 1'b0;
    logic i_areset;
    always #5 i_clk = ~i_clk;

    counter64_snapshot_reader_if #(.IDX_W(IDX_W)) api();

    logic [32*N-1:0] i_msb, i_lsb;
    logic [N-1:0]    o_lsb_sample, o_cnt_rst;

    counter64_snapshot_reader #(.NUM_COUNTERS(N), .IDX_W(IDX_W)) dut (
        .i_areset     (i_areset),
        .i_clk        (i_clk),
        .api          (api),
        .i_msb        (i_msb),
        .i_lsb        (i_lsb),
        .o_lsb_sample (o_lsb_sample),
        .o_cnt_rst    (o_cnt_rst)
    );

    // Counter bank model
    logic [63:0] cnt [N];
    logic [31:0] lsb_smp [N];
    logic [N-1:0] clr_q = '0;
    logic [63:0] preset_val [N];
    logic [N-1:0] preset_en = '0;
    logic [N-1:0] inc_en = '0;

    always @(posedge i_clk) begin
        for (int k = 0; k < N; k++) begin
            if (clr_q[k])          cnt[k] <= '0;
            else if (preset_en[k]) cnt[k] <= preset_val[k];
            else if (inc_en[k])    cnt[k] <= cnt[k] + 64'd1;
            if (o_lsb_sample[k])   lsb_smp[k] <= cnt[k][31:0];
        end
        clr_q <= o_cnt_rst;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            i_msb[32*k +: 32] = cnt[k][63:32];
            i_lsb[32*k +: 32] = lsb_smp[k];
        end
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          lat;
        int          issue;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    bit leak = 1'b0;
    bit overlap = 1'b0;

    // Monitor: pops one expectation per o_ready pulse
    always @(negedge i_clk) begin
        if (api.ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ready: got data=%h, want no response", api.read_data);
            end else begin
                e = sb.pop_front();
                if (api.read_data !== e.data || (cyc - e.issue) != e.lat) begin
                    fails++;
                    $display("FAIL %s: got data=%h lat=%0d, want data=%h lat=%0d",
                             e.name, api.read_data, cyc - e.issue, e.data, e.lat);
                end
            end
        end else if (api.read_data !== 32'd0) begin
            leak = 1'b1;
        end
        if (|(o_lsb_sample & o_cnt_rst)) overlap = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; holds i_cs for one cycle and returns at the next negedge.
    task automatic issue(input logic we, input logic [3:0] idx, input logic [1:0] ofs,
                         input logic [31:0] wd, input bit push, input logic [31:0] exp,
                         input int lat, input string name);
        exp_t x;
        api.cs         = 1'b1;
        api.we         = we;
        api.address    = {idx, ofs};
        api.write_data = wd;
        if (push) begin
            x.name = name; x.data = exp; x.lat = lat; x.issue = cyc;
            sb.push_back(x);
        end
        @(negedge i_clk);
        api.cs = 1'b0;
        api.we = 1'b0;
        api.write_data = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (api.busy && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (api.busy) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy still 1 after 20 cycles, want 0", name);
        end
    endtask

    initial begin
        i_areset = 1'b1;
        api.cs = 1'b0; api.we = 1'b0; api.address = '0; api.write_data = '0;
        for (int k = 0; k < N; k++) begin
            lsb_smp[k]    = '0;
            preset_val[k] = {32'(k), 32'(k)};
        end
        preset_val[0] = 64'hA5A5A5A5_12345678;
        preset_val[1] = 64'h11111111_22222222;
        preset_val[3] = 64'h0;
        preset_val[5] = 64'hDEADBEEF_CAFEF00D;
        preset_val[6] = 64'h01234567_89ABCDEF;
        preset_en = '1;
        inc_en    = 8'h08;
        repeat (3) @(negedge i_clk);
        preset_en = '0;
        i_areset  = 1'b0;
        @(negedge i_clk);

        chk("rst_ready", 64'(api.ready), 64'd0);
        chk("rst_rdata", 64'(api.read_data), 64'd0);
        chk("rst_busy", 64'(api.busy), 64'd0);
        chk("rst_lsb_sample", 64'(o_lsb_sample), 64'd0);
        chk("rst_cnt_rst", 64'(o_cnt_rst), 64'd0);

        // MSB read counter 0: strobe at T1 only, ready at T3
        issue(1'b0, 4'd0, 2'd0, 32'd0, 1'b1, 32'hA5A5A5A5, 3, "msb_c0");
        chk("sample_t1_c0", 64'(o_lsb_sample), 64'h01);
        @(negedge i_clk);
        chk("sample_t2_c0", 64'(o_lsb_sample), 64'h00);
        wait_idle("msb_c0");
        issue(1'b0, 4'd0, 2'd1, 32'd0, 1'b1, 32'h12345678, 2, "lsb_c0");
        wait_idle("lsb_c0");

        // Coherence: sample edge sees 0x1_FFFFFFFF
        preset_en[3] = 1'b1; preset_val[3] = 64'h00000001_FFFFFFFF;
        issue(1'b0, 4'd3, 2'd0, 32'd0, 1'b1, 32'h00000001, 3, "coh1_msb");
        preset_en[3] = 1'b0;
        wait_idle("coh1_msb");
        issue(1'b0, 4'd3, 2'd1, 32'd0, 1'b1, 32'hFFFFFFFF, 2, "coh1_lsb");
        wait_idle("coh1_lsb");

        // Coherence: sample edge sees the wrapped value 0x2_00000000
        preset_en[3] = 1'b1;
        @(negedge i_clk);
        preset_en[3] = 1'b0;
        issue(1'b0, 4'd3, 2'd0, 32'd0, 1'b1, 32'h00000002, 3, "coh2_msb");
        wait_idle("coh2_msb");
        issue(1'b0, 4'd3, 2'd1, 32'd0, 1'b1, 32'h00000000, 2, "coh2_lsb");
        wait_idle("coh2_lsb");

        // CTRL clear counter 5
        issue(1'b1, 4'd5, 2'd2, 32'h1, 1'b1, 32'd0, 2, "ctrl_clr_c5");
        chk("cnt_rst_c5", 64'(o_cnt_rst), 64'h20);
        @(negedge i_clk);
        chk("cnt_rst_c5_end", 64'(o_cnt_rst), 64'h00);
        wait_idle("ctrl_clr_c5");
        issue(1'b0, 4'd5, 2'd0, 32'd0, 1'b1, 32'd0, 3, "msb_c5_clr");
        wait_idle("msb_c5_clr");
        issue(1'b0, 4'd5, 2'd1, 32'd0, 1'b1, 32'd0, 2, "lsb_c5_clr");
        wait_idle("lsb_c5_clr");

        // CTRL write bit0=0: no clear
        issue(1'b1, 4'd6, 2'd2, 32'hFFFFFFFE, 1'b1, 32'd0, 2, "ctrl_nop_c6");
        chk("cnt_rst_none", 64'(o_cnt_rst), 64'h00);
        wait_idle("ctrl_nop_c6");
        issue(1'b0, 4'd6, 2'd0, 32'd0, 1'b1, 32'h01234567, 3, "msb_c6");
        wait_idle("msb_c6");

        // Reserved offset, CTRL read, out-of-range index
        issue(1'b0, 4'd0, 2'd3, 32'd0, 1'b1, 32'd0, 2, "rsvd_rd");
        wait_idle("rsvd_rd");
        issue(1'b0, 4'd1, 2'd2, 32'd0, 1'b1, 32'd0, 2, "ctrl_rd");
        wait_idle("ctrl_rd");
        issue(1'b0, 4'd9, 2'd0, 32'd0, 1'b1, 32'd0, 3, "msb_idx9");
        chk("sample_idx9", 64'(o_lsb_sample), 64'h00);
        wait_idle("msb_idx9");
        issue(1'b0, 4'd9, 2'd1, 32'd0, 1'b1, 32'd0, 2, "lsb_idx9");
        wait_idle("lsb_idx9");

        // i_cs during SAMPLE is ignored
        issue(1'b0, 4'd0, 2'd0, 32'd0, 1'b1, 32'hA5A5A5A5, 3, "msb_c0_busy");
        chk("busy_sample", 64'(api.busy), 64'd1);
        issue(1'b0, 4'd1, 2'd1, 32'd0, 1'b0, 32'd0, 0, "ignored");
        chk("busy_resp", 64'(api.busy), 64'd1);
        wait_idle("msb_c0_busy");
        @(negedge i_clk);

        // Reset during SAMPLE aborts with no response
        issue(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 32'd0, 0, "aborted");
        chk("abort_sample_pre", 64'(o_lsb_sample), 64'h01);
        #2 i_areset = 1'b1;
        #1;
        chk("abort_lsb_sample", 64'(o_lsb_sample), 64'h00);
        chk("abort_busy", 64'(api.busy), 64'd0);
        chk("abort_ready", 64'(api.ready), 64'd0);
        chk("abort_cnt_rst", 64'(o_cnt_rst), 64'h00);
        repeat (2) @(negedge i_clk);
        i_areset = 1'b0;
        repeat (2) @(negedge i_clk);
        issue(1'b0, 4'd0, 2'd0, 32'd0, 1'b1, 32'hA5A5A5A5, 3, "msb_after_rst");
        wait_idle("msb_after_rst");

        repeat (4) @(negedge i_clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("rdata_zero_when_idle", 64'(leak), 64'd0);
        chk("strobe_overlap", 64'(overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
